// File: rtl/alu_rr_sched.sv
// Round-robin scheduler that time-shares one external add/inc/sub/dec ALU between
// two requesters; a single transaction is in flight at a time (IDLE -> EXEC -> RESP).
module alu_rr_sched #(
  parameter int DW   = 32,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [DW-1:0]   rsp_data,
  output logic [3:0]      rsp_flags,
  output logic            rsp_err,
  output logic [OPW-1:0]  alu_op1,
  output logic [DW-1:0]   alu_in0,
  output logic [DW-1:0]   alu_in1,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_carryout,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  input  logic            alu_n,
  output logic            busy,
  output logic            grant_id,
  output logic [CNTW-1:0] done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [OPW-1:0] OP_NOP = {OPW{1'b1}};
  localparam logic [OPW-1:0] OP_MAX = {{(OPW-2){1'b0}}, 2'b11};

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return (op <= OP_MAX);
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ptr;
  logic            r_id;
  logic            r_err;
  logic [OPW-1:0]  r_op;
  logic [OPW-1:0]  r_alu_op1;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_data;
  logic [3:0]      r_flags;
  logic [CNTW-1:0] r_cnt;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_accept;
  logic            w_rsp_hs;
  logic            w_req0_ready;
  logic            w_req1_ready;
  logic [OPW-1:0]  w_sel_op;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;

  // r_ptr=0 gives req0 priority on a tie; a lone requester always wins.
  assign w_gnt0   = req0_valid & (~req1_valid | ~r_ptr);
  assign w_gnt1   = req1_valid & (~req0_valid |  r_ptr);
  assign w_sel_op = w_gnt1 ? req1_op : req0_op;
  assign w_sel_a  = w_gnt1 ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt1 ? req1_b  : req0_b;

  // Next-state decode, request handshake and response handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_accept     = 1'b0;
    w_rsp_hs     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req0_ready = w_gnt0;
        w_req1_ready = w_gnt1;
        if (w_gnt0 | w_gnt1) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_hs = r_id ? rsp1_ready : rsp0_ready;
        if (w_rsp_hs) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch, ALU opcode, result capture, pointer and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= 1'b0;
      r_id      <= 1'b0;
      r_op      <= {OPW{1'b0}};
      r_a       <= {DW{1'b0}};
      r_b       <= {DW{1'b0}};
      r_alu_op1 <= OP_NOP;
      r_data    <= {DW{1'b0}};
      r_flags   <= 4'b0000;
      r_err     <= 1'b0;
      r_cnt     <= {CNTW{1'b0}};
    end else if (w_accept) begin
      r_id      <= w_gnt1;
      r_op      <= w_sel_op;
      r_a       <= w_sel_a;
      r_b       <= w_sel_b;
      r_alu_op1 <= op_legal(w_sel_op) ? w_sel_op : OP_NOP;
    end else if (r_state == ST_EXEC) begin
      r_alu_op1 <= OP_NOP;
      if (op_legal(r_op)) begin
        r_data  <= alu_out;
        r_flags <= {alu_n, alu_zero, alu_overflow, alu_carryout};
        r_err   <= 1'b0;
      end else begin
        r_data  <= {DW{1'b0}};
        r_flags <= 4'b0000;
        r_err   <= 1'b1;
      end
    end else if (w_rsp_hs) begin
      r_ptr <= ~r_id;
      if (r_cnt != {CNTW{1'b1}}) begin
        r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;
  assign rsp0_valid = (r_state == ST_RESP) & ~r_id;
  assign rsp1_valid = (r_state == ST_RESP) &  r_id;
  assign rsp_data   = r_data;
  assign rsp_flags  = r_flags;
  assign rsp_err    = r_err;
  assign alu_op1    = r_alu_op1;
  assign alu_in0    = r_a;
  assign alu_in1    = r_b;
  assign busy       = (r_state != ST_IDLE);
  assign grant_id   = r_id;
  assign done_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: behavioural ALU stub, directed vector table, reset-mid-op
// sequence and randomized transactions checked against a transaction-level model.
module tb_alu_rr_sched;

  localparam int CNTW_TB = 2;
  localparam int CMAX    = (1 << CNTW_TB) - 1;

  logic               clk;
  logic               rst_n;
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [3:0]         req0_op, req1_op;
  logic [31:0]        req0_a, req0_b, req1_a, req1_b;
  logic               rsp0_valid, rsp1_valid;
  logic               rsp0_ready, rsp1_ready;
  logic [31:0]        rsp_data;
  logic [3:0]         rsp_flags;
  logic               rsp_err;
  logic [3:0]         alu_op1;
  logic [31:0]        alu_in0, alu_in1, alu_out;
  logic               alu_carryout, alu_overflow, alu_zero, alu_n;
  logic               busy, grant_id;
  logic [CNTW_TB-1:0] done_cnt;
  logic [35:0]        alu_res;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;
  logic m_ptr  = 1'b0;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [3:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [3:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    int          hold;
    logic        exp_id;
    logic [31:0] exp_data;
    logic [3:0]  exp_flags;
    logic        exp_err;
  } vec_t;

  alu_rr_sched #(.DW(32), .OPW(4), .CNTW(CNTW_TB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_op1(alu_op1), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_out(alu_out),
    .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_n(alu_n),
    .busy(busy), .grant_id(grant_id), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU arithmetic: returns {N, zero, overflow, carryout, result}.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] bb;
    logic        sub;
    logic [32:0] s;
    logic        v;
    bb  = (op == 4'd1 || op == 4'd3) ? 32'd1 : b;
    sub = (op == 4'd2 || op == 4'd3);
    if (sub) s = {1'b0, a} + {1'b0, ~bb} + 33'd1;
    else     s = {1'b0, a} + {1'b0, bb};
    if (sub) v = (a[31] != bb[31]) && (s[31] != a[31]);
    else     v = (a[31] == bb[31]) && (s[31] != a[31]);
    return {s[31], (s[31:0] == 32'd0), v, s[32], s[31:0]};
  endfunction

  // The stub emits junk for non-arithmetic opcodes so a leak into the response shows.
  always_comb begin
    if (alu_op1 <= 4'd3) alu_res = ref_alu(alu_op1, alu_in0, alu_in1);
    else                 alu_res = {4'hF, 32'hDEADBEEF};
  end
  assign {alu_n, alu_zero, alu_overflow, alu_carryout, alu_out} = alu_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fill expectations of a random vector from the arbitration rule and arithmetic.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    logic [3:0] op;
    logic [35:0] res;
    r = v;
    r.exp_id = (v.v0 && v.v1) ? m_ptr : v.v1;
    op = r.exp_id ? v.op1 : v.op0;
    if (op > 4'd3) begin
      r.exp_err = 1'b1; r.exp_data = 32'd0; r.exp_flags = 4'd0;
    end else begin
      res = ref_alu(op, r.exp_id ? v.a1 : v.a0, r.exp_id ? v.b1 : v.b0);
      r.exp_err = 1'b0; r.exp_data = res[31:0]; r.exp_flags = res[35:32];
    end
    return r;
  endfunction

  // One transaction, entered and left just after a rising edge with the DUT idle.
  task automatic run_txn(input vec_t v);
    logic [3:0]  g_op;
    logic [31:0] g_a, g_b;
    g_op = v.exp_id ? v.op1 : v.op0;
    g_a  = v.exp_id ? v.a1  : v.a0;
    g_b  = v.exp_id ? v.b1  : v.b0;
    req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
    #1;
    check("idle_req0_ready", req0_ready, v.v0 && !v.exp_id);
    check("idle_req1_ready", req1_ready, v.v1 && v.exp_id);
    check("idle_busy", busy, 1'b0);
    check("idle_alu_op1", alu_op1, 4'hF);
    @(posedge clk); #1;
    if (v.exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
    #1;
    check("exec_req0_ready", req0_ready, 1'b0);
    check("exec_req1_ready", req1_ready, 1'b0);
    check("exec_busy", busy, 1'b1);
    check("exec_grant_id", grant_id, v.exp_id);
    check("exec_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("exec_alu_op1", alu_op1, v.exp_err ? 4'hF : g_op);
    if (!v.exp_err) begin
      check("exec_alu_in0", alu_in0, g_a);
      check("exec_alu_in1", alu_in1, g_b);
    end
    @(posedge clk); #1;
    if (v.exp_id) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    for (int h = 0; h <= v.hold; h++) begin
      if (h == v.hold) begin
        if (v.exp_id) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      end
      #1;
      check("rsp0_valid", rsp0_valid, !v.exp_id);
      check("rsp1_valid", rsp1_valid, v.exp_id);
      check("rsp_data", rsp_data, v.exp_data);
      check("rsp_flags", rsp_flags, v.exp_flags);
      check("rsp_err", rsp_err, v.exp_err);
      check("resp_ready", {req0_ready, req1_ready}, 2'b00);
      check("resp_busy", busy, 1'b1);
      check("resp_alu_op1", alu_op1, 4'hF);
      @(posedge clk); #1;
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_ptr = ~v.exp_id;
    if (m_cnt < CMAX) m_cnt++;
    #1;
    check("done_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("done_busy", busy, 1'b0);
    check("done_cnt", done_cnt, m_cnt);
  endtask

  task automatic idle_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("noreq_ready", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk); #1;
    check("noreq_busy", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    tbl[0] = '{1, 1, 4'd2, 32'd9, 32'd4, 4'd1, 32'hFFFFFFFF, 32'd0, 10, 0, 32'd5, 4'b0001, 0};
    tbl[1] = '{1, 1, 4'd2, 32'd9, 32'd4, 4'd1, 32'hFFFFFFFF, 32'd0, 0, 1, 32'd0, 4'b0101, 0};
    tbl[2] = '{1, 1, 4'd2, 32'd9, 32'd4, 4'd1, 32'hFFFFFFFF, 32'd0, 1, 0, 32'd5, 4'b0001, 0};
    tbl[3] = '{1, 0, 4'd0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0, 0, 32'd12, 4'b0000, 0};
    tbl[4] = '{0, 1, 4'd0, 32'd0, 32'd0, 4'd4, 32'd3, 32'd4, 2, 1, 32'd0, 4'b0000, 1};
    tbl[5] = '{0, 1, 4'd0, 32'd0, 32'd0, 4'd2, 32'd7, 32'd7, 0, 1, 32'd0, 4'b0101, 0};
    tbl[6] = '{1, 0, 4'd3, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 0, 0, 32'hFFFFFFFF, 4'b1000, 0};
    tbl[7] = '{1, 0, 4'd0, 32'h7FFFFFFF, 32'd1, 4'd0, 32'd0, 32'd0, 0, 0, 32'h80000000, 4'b1010, 0};

    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 1'b0);
    check("rst_alu_op1", alu_op1, 4'hF);
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("rst_err", rsp_err, 1'b0);
    check("rst_data", rsp_data, 32'd0);
    check("rst_done_cnt", done_cnt, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Put the pointer on req1, then reset during EXEC.
    v = '{1, 0, 4'd0, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 0, 0, 32'd0, 4'd0, 0};
    run_txn(predict(v));
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd3; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd8; req1_b = 32'd0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    check("mid_rst_done_cnt", done_cnt, 0);
    check("mid_rst_alu_op1", alu_op1, 4'hF);
    m_ptr = 1'b0; m_cnt = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
    end
    v = '{1, 1, 4'd0, 32'd10, 32'd20, 4'd2, 32'd1, 32'd2, 0, 0, 32'd0, 4'd0, 0};
    v = predict(v);
    check("post_rst_pred_id", v.exp_id, 1'b0);
    run_txn(v);

    // Back-to-back randomized traffic; counter saturates along the way.
    for (int i = 0; i < 60; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      v.v0 = pat[0]; v.v1 = pat[1];
      v.op0 = 4'($urandom_range(0, 5)); v.op1 = 4'($urandom_range(0, 5));
      v.a0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom();
      v.b0 = ($urandom_range(0, 3) == 0) ? v.a0 : $urandom();
      v.a1 = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom();
      v.b1 = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom();
      v.hold = $urandom_range(0, 2);
      run_txn(predict(v));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
